bcd_to_binary: RTL and testbench
================================

# bcd_to_binary

- Iterative three-digit BCD-to-binary converter: the inverse of the binary-to-BCD digit path.
- Takes hundreds/tens/ones digits from the user-entry and threshold-setting logic and returns a 10-bit binary value for the heart-rate comparison datapath.
- Conversion is sequential, one weight-add per clock, so no multipliers are needed.
- Start/busy/done handshake; invalid-digit detection.

## Interface
Parameters:
- none; all widths and weights are constants in the shared package.

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  conversion request, level-sampled while idle
- d100  in  4  hundreds digit, BCD
- d10  in  4  tens digit, BCD
- d1  in  4  ones digit, BCD
- binary  out  10  converted value 0..999, held until next completion
- over255  out  1  binary > 255, registered with binary
- error  out  1  last request had a digit > 9, registered with binary
- busy  out  1  conversion in progress
- done  out  1  single-cycle completion pulse

## Operation
- States: IDLE, RUN.
- Reset (any time, including mid-conversion): state IDLE; binary=0, over255=0, error=0, busy=0, done=0. Internal counters and accumulator are cleared.
- IDLE, start=1 at an edge:
  - latch d100/d10/d1 into down-counters h/t/o; clear accumulator acc (10 bit); go RUN; busy<=1.
  - If any digit > 9: load h=t=o=0 and set the internal err flag. Otherwise err=0.
- IDLE, start=0: hold; done<=0.
- RUN, priority per edge:
  - h>0: h--, acc+=100
  - else t>0: t--, acc+=10
  - else o>0: o--, acc+=1
  - else: binary<=acc, over255<=(acc>255), error<=err, done<=1, busy<=0, go IDLE.
- start while busy: ignored. Input digits are not re-sampled during RUN.
- start held high continuously: a new conversion is captured at the first edge after done, i.e. the IDLE cycle in which done=1. Back-to-back conversions are separated by exactly that one cycle.
- Arithmetic: acc never exceeds 999, so 10 bits suffice and no wrap is possible. On error, binary=0.

## Timing
- Start sampled at edge k; N = h+t+o for valid digits (N=0 for invalid digits).
- busy=1 from edge k through edge k+N+1, exclusive.
- binary, over255, error and done update at edge k+N+1. done is high for exactly that one cycle.
- Latency range: 1 cycle (000 or invalid digits) to 28 cycles (999).
- binary is stable between completions. It changes only on a done edge or on reset.

## Structure
Shared package holds:
- DIGIT_W=4, BIN_W=10, DIGIT_MAX=9
- weights W100=100, W10=10, W1=1
- LIMIT8=255
- state enum {IDLE, RUN}

No sub-module. A single FSM plus three digit down-counters and the accumulator is natural at this size.

## Test plan
- Reset mid-RUN: apply 9,9,9, start, assert reset_n=0 at cycle 5 -> all outputs 0 immediately (asynchronous), state IDLE. A fresh request after release converts correctly.
- 2,5,5 with a single start pulse -> done exactly 13 cycles after the start edge, binary=255, over255=0, error=0, busy high for 13 cycles.
- 9,9,9 -> done at +28 cycles, binary=999, over255=1. Then 0,0,0 -> done at +1, binary=0, over255=0.
- Invalid digits 1,A,3 -> done at +1, error=1, binary=0. A following valid 0,7,2 -> error=0, binary=72.
- Busy rejection: start 1,2,0 (N=3); pulse start with 9,9,9 on cycle 2 -> ignored, binary=120. Digits changing during RUN have no effect.
- start held high with 0,4,2 constant -> done pulses every 8 cycles (6 RUN cycles + done edge + IDLE capture), binary=42 each time, never two consecutive done cycles.

Source files
------------

// File: rtl/bcd_to_binary_pkg.sv
// Shared constants and types for the three-digit BCD-to-binary converter.
// Weights are pre-sized to the accumulator width so adds need no casting.
package bcd_to_binary_pkg;

    localparam int DIGIT_W = 4;
    localparam int BIN_W   = 10;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    localparam logic [BIN_W-1:0] W100   = 10'd100;
    localparam logic [BIN_W-1:0] W10    = 10'd10;
    localparam logic [BIN_W-1:0] W1     = 10'd1;
    localparam logic [BIN_W-1:0] LIMIT8 = 10'd255;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    function automatic logic any_invalid(input logic [DIGIT_W-1:0] a,
                                         input logic [DIGIT_W-1:0] b,
                                         input logic [DIGIT_W-1:0] c);
        return (a > DIGIT_MAX) || (b > DIGIT_MAX) || (c > DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// Request/result bundle between the digit-entry logic and the converter.
interface bcd_to_binary_if;
    import bcd_to_binary_pkg::*;

    logic               start;
    logic [DIGIT_W-1:0] d100;
    logic [DIGIT_W-1:0] d10;
    logic [DIGIT_W-1:0] d1;
    logic [BIN_W-1:0]   binary;
    logic               over255;
    logic               error;
    logic               busy;
    logic               done;

    modport master (output start, d100, d10, d1,
                    input  binary, over255, error, busy, done);
    modport slave  (input  start, d100, d10, d1,
                    output binary, over255, error, busy, done);
endinterface

// File: rtl/bcd_to_binary.sv
// Iterative BCD-to-binary: one weighted add per clock, hundreds first,
// so a 999 request takes 27 add cycles plus the completion edge.
module bcd_to_binary
    import bcd_to_binary_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    bcd_to_binary_if.slave  bus
);

    state_t             r_state, w_state;
    logic [DIGIT_W-1:0] r_h, r_t, r_o, w_h, w_t, w_o;
    logic [BIN_W-1:0]   r_acc, w_acc;
    logic               r_err, w_err;
    logic [BIN_W-1:0]   r_binary, w_binary;
    logic               r_over255, w_over255;
    logic               r_error, w_error;
    logic               r_busy, w_busy;
    logic               r_done, w_done;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_h       <= '0;
            r_t       <= '0;
            r_o       <= '0;
            r_acc     <= '0;
            r_err     <= 1'b0;
            r_binary  <= '0;
            r_over255 <= 1'b0;
            r_error   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_h       <= w_h;
            r_t       <= w_t;
            r_o       <= w_o;
            r_acc     <= w_acc;
            r_err     <= w_err;
            r_binary  <= w_binary;
            r_over255 <= w_over255;
            r_error   <= w_error;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_h       = r_h;
        w_t       = r_t;
        w_o       = r_o;
        w_acc     = r_acc;
        w_err     = r_err;
        w_binary  = r_binary;
        w_over255 = r_over255;
        w_error   = r_error;
        w_busy    = r_busy;
        w_done    = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state = RUN;
                    w_busy  = 1'b1;
                    w_acc   = '0;
                    // Bad digits skip straight to completion with a zero result.
                    if (any_invalid(bus.d100, bus.d10, bus.d1)) begin
                        w_h   = '0;
                        w_t   = '0;
                        w_o   = '0;
                        w_err = 1'b1;
                    end else begin
                        w_h   = bus.d100;
                        w_t   = bus.d10;
                        w_o   = bus.d1;
                        w_err = 1'b0;
                    end
                end
            end
            RUN: begin
                if (r_h != '0) begin
                    w_h   = r_h - 1'b1;
                    w_acc = r_acc + W100;
                end else if (r_t != '0) begin
                    w_t   = r_t - 1'b1;
                    w_acc = r_acc + W10;
                end else if (r_o != '0) begin
                    w_o   = r_o - 1'b1;
                    w_acc = r_acc + W1;
                end else begin
                    w_binary  = r_acc;
                    w_over255 = (r_acc > LIMIT8);
                    w_error   = r_err;
                    w_done    = 1'b1;
                    w_busy    = 1'b0;
                    w_state   = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign bus.binary  = r_binary;
    assign bus.over255 = r_over255;
    assign bus.error   = r_error;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed and random checks of the BCD converter against an arithmetic model.
module tb_bcd_to_binary;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_fails;

    bcd_to_binary_if bus ();

    bcd_to_binary dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_value(input int a, input int b, input int c);
        if (a > 9 || b > 9 || c > 9) return 0;
        return 100 * a + 10 * b + c;
    endfunction

    function automatic int model_lat(input int a, input int b, input int c);
        if (a > 9 || b > 9 || c > 9) return 1;
        return a + b + c + 1;
    endfunction

    // Single start pulse; checks latency, busy, result hold and final outputs.
    task automatic convert(input string tag, input int a, input int b, input int c,
                           input int prev);
        int lat;
        int exp_v;
        bit got;
        exp_v = model_value(a, b, c);
        @(negedge clock);
        bus.d100  = 4'(a);
        bus.d10   = 4'(b);
        bus.d1    = 4'(c);
        bus.start = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0;
        check({tag, "_busy_on"}, int'(bus.busy), 1);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clock);
            #1 lat++;
            if (bus.done) got = 1'b1;
            else begin
                check({tag, "_busy_run"}, int'(bus.busy), 1);
                check({tag, "_hold"}, int'(bus.binary), prev);
            end
        end
        check({tag, "_latency"}, lat, model_lat(a, b, c));
        check({tag, "_binary"}, int'(bus.binary), exp_v);
        check({tag, "_over255"}, int'(bus.over255), int'(exp_v > 255));
        check({tag, "_error"}, int'(bus.error), int'(a > 9 || b > 9 || c > 9));
        check({tag, "_busy_end"}, int'(bus.busy), 0);
        @(posedge clock);
        #1 check({tag, "_done_pulse"}, int'(bus.done), 0);
        check({tag, "_stable"}, int'(bus.binary), exp_v);
    endtask

    initial begin
        int prev;
        int lat;
        int last_done;
        int n_done;
        bit got;
        n_checks  = 0;
        n_fails   = 0;
        bus.start = 1'b0;
        bus.d100  = '0;
        bus.d10   = '0;
        bus.d1    = '0;
        reset_n   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_binary", int'(bus.binary), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_error", int'(bus.error), 0);
        check("rst_over", int'(bus.over255), 0);
        @(negedge clock) reset_n = 1'b1;

        convert("c255", 2, 5, 5, 0);
        convert("c999", 9, 9, 9, 255);
        convert("c000", 0, 0, 0, 999);
        convert("c999b", 9, 9, 9, 0);
        convert("inv1A3", 1, 10, 3, 999);
        convert("c072", 0, 7, 2, 0);

        // Asynchronous reset in the middle of a long conversion.
        @(negedge clock);
        bus.d100 = 4'd9; bus.d10 = 4'd9; bus.d1 = 4'd9; bus.start = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_binary", int'(bus.binary), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_over", int'(bus.over255), 0);
        @(negedge clock) reset_n = 1'b1;
        convert("post_rst", 2, 5, 5, 0);

        // Request while busy is ignored; digits move during RUN.
        @(negedge clock);
        bus.d100 = 4'd1; bus.d10 = 4'd2; bus.d1 = 4'd0; bus.start = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0;
        @(negedge clock);
        bus.d100 = 4'd9; bus.d10 = 4'd9; bus.d1 = 4'd9; bus.start = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0;
        bus.d100 = 4'd5; bus.d10 = 4'd5; bus.d1 = 4'd5;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clock);
            #1 lat++;
            if (bus.done) got = 1'b1;
        end
        check("busy_rej_lat", lat, 4);
        check("busy_rej_bin", int'(bus.binary), 120);
        @(posedge clock);
        #1 check("busy_rej_idle", int'(bus.busy), 0);

        // Start held high: one idle capture cycle between conversions.
        @(negedge clock);
        bus.d100 = 4'd0; bus.d10 = 4'd4; bus.d1 = 4'd2; bus.start = 1'b1;
        last_done = 0;
        n_done = 0;
        prev = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clock);
            #1;
            if (bus.done) begin
                n_done++;
                check("held_bin", int'(bus.binary), 42);
                check("held_period", cyc - last_done, (n_done == 1) ? 8 : 8);
                check("held_no_double", prev, 0);
                last_done = cyc;
            end
            prev = int'(bus.done);
        end
        check("held_count", n_done, 5);
        @(negedge clock) bus.start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clock);
            #1 if (!bus.busy) got = 1'b1;
        end
        check("held_drain", int'(got), 1);
        repeat (2) @(posedge clock);
        #1;

        // Random digits, a few of them out of BCD range.
        prev = int'(bus.binary);
        for (int n = 0; n < 25; n++) begin
            int a, b, c;
            a = $urandom_range(0, 11);
            b = $urandom_range(0, 11);
            c = $urandom_range(0, 11);
            convert("rand", a, b, c, prev);
            prev = model_value(a, b, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
